// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART transmit-side arbitration logic.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } tx_arb_state_e;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int REQ_ID_W(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the UART transmit arbiter: request level, byte, grant and completion.
interface uart_tx_arbiter_if #(
  parameter int DATA_BITS = 8,
  parameter int NUM_REQ   = 4
);

  // Handshake: Req[i] is a level held with a stable Req_Data[i] until Gnt[i] pulses for
  // one cycle, which means the byte has been captured; Req[i] may then drop. Dropping
  // Req[i] before Gnt[i] withdraws the request. Done[i] pulses once the byte has left.
  logic [NUM_REQ-1:0]                Req;
  logic [NUM_REQ-1:0][DATA_BITS-1:0] Req_Data;
  logic [NUM_REQ-1:0]                Gnt;
  logic [NUM_REQ-1:0]                Done;

  modport master (output Req, output Req_Data, input Gnt, input Done);
  modport slave  (input Req, input Req_Data, output Gnt, output Done);

endinterface

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first requesting index at or after the pointer, wrapping.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_win,
  output logic               o_valid
);

  function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester is assigned last and wins.
  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[rot_idx(i_ptr, k)]) begin
        o_win   = rot_idx(i_ptr, k);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART transmitter: grants one requester, drives the start
// handshake against Tx_Busy, and reports completion or a start timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 64
) (
  input  logic                          SysClk,
  input  logic                          Rst,
  uart_tx_arbiter_if.slave              req_if,
  output logic [DATA_BITS-1:0]          Tx_Data,
  output logic                          Transmit_Start,
  input  logic                          Tx_Busy,
  output logic                          Timeout_Err,
  output logic [REQ_ID_W(NUM_REQ)-1:0]  Err_Id,
  output tx_arb_state_e                 Dbg_State
);

  localparam int ID_W  = REQ_ID_W(NUM_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(START_TIMEOUT);
  localparam logic [ID_W-1:0]    ID_LAST  = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  tx_arb_state_e        r_state;
  tx_arb_state_e        w_next;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_owner;
  logic [ID_W-1:0]      r_err_id;
  logic [ID_W-1:0]      w_win;
  logic                 w_valid;
  logic                 w_grant;
  logic                 w_timeout;
  logic                 w_done;
  logic                 w_start;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_BITS-1:0] r_tx_data;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_timeout;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req   (req_if.Req),
    .i_ptr   (r_ptr),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_grant) w_next = START;
      START: begin
        if (Tx_Busy)        w_next = WAIT_DONE;
        else if (w_timeout) w_next = IDLE;
      end
      WAIT_DONE: if (w_done) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // A busy transmitter in IDLE belongs to someone else, so no grant is issued then.
  always_comb begin
    w_grant   = 1'b0;
    w_timeout = 1'b0;
    w_done    = 1'b0;
    w_start   = 1'b0;
    case (r_state)
      IDLE:      w_grant = w_valid && !Tx_Busy;
      START: begin
        w_start   = 1'b1;
        w_timeout = !Tx_Busy && (r_cnt >= CNT_LAST);
      end
      WAIT_DONE: w_done = !Tx_Busy;
      default:   ;
    endcase
  end

  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      r_ptr     <= '0;
      r_owner   <= '0;
      r_err_id  <= '0;
      r_cnt     <= '0;
      r_tx_data <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_gnt     <= '0;
      r_done    <= '0;
      r_timeout <= 1'b0;
      if (w_grant) begin
        r_tx_data <= req_if.Req_Data[w_win];
        r_gnt     <= ONE_HOT0 << w_win;
        r_owner   <= w_win;
        r_ptr     <= (w_win == ID_LAST) ? '0 : w_win + 1'b1;
        r_cnt     <= '0;
      end else if (r_state == START && r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_timeout <= 1'b1;
        r_err_id  <= r_owner;
      end
      if (w_done) r_done <= ONE_HOT0 << r_owner;
    end
  end

  assign req_if.Gnt     = r_gnt;
  assign req_if.Done    = r_done;
  assign Tx_Data        = r_tx_data;
  assign Transmit_Start = w_start;
  assign Timeout_Err    = r_timeout;
  assign Err_Id         = r_err_id;
  assign Dbg_State      = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a transaction-level grant-order model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int TO = 64;

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic [DW-1:0] tx_data;
  logic          transmit_start;
  logic          tx_busy;
  logic          timeout_err;
  logic [1:0]    err_id;
  tx_arb_state_e dbg_state;

  uart_tx_arbiter_if #(.DATA_BITS(DW), .NUM_REQ(NR)) arb_if();

  uart_tx_arbiter #(
    .DATA_BITS     (DW),
    .NUM_REQ       (NR),
    .START_TIMEOUT (TO)
  ) dut (
    .SysClk         (sys_clk),
    .Rst            (rst_n),
    .req_if         (arb_if),
    .Tx_Data        (tx_data),
    .Transmit_Start (transmit_start),
    .Tx_Busy        (tx_busy),
    .Timeout_Err    (timeout_err),
    .Err_Id         (err_id),
    .Dbg_State      (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running required stopped");
    $fatal(1);
  end

  // ---------------- shared state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  int         m_ptr    = 0;
  logic [7:0] bd [NR];
  int         tx_rise  = 1;
  int         tx_hold  = 1;
  bit         no_resp  = 1'b0;
  bit         force_busy = 1'b0;

  logic [9:0] exp_gnt_q  [$];
  logic [9:0] exp_done_q [$];
  logic [1:0] exp_err_q  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- transmitter model ----------------
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (force_busy) begin
        tx_busy = 1'b1;
      end else if (transmit_start && !no_resp && rst_n) begin
        repeat (tx_rise) begin
          @(posedge sys_clk);
        end
        #1;
        tx_busy = 1'b1;
        repeat (tx_hold) begin
          @(posedge sys_clk);
        end
        #1;
        tx_busy = 1'b0;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Requests raised together and held until granted are served once each, in rotating
  // order starting at the pointer; the pointer then sits just past the last one served.
  task automatic model_plan(input logic [3:0] mask, input bit to_mode);
    int last;
    last = m_ptr;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (mask[i]) begin
        exp_gnt_q.push_back({2'(i), bd[i]});
        if (to_mode) exp_err_q.push_back(2'(i));
        else         exp_done_q.push_back({2'(i), bd[i]});
        last = i;
      end
    end
    m_ptr = (last + 1) % NR;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NR; i++) bd[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [9:0] mon_e;
  logic [1:0] mon_id;
  logic [3:0] mon_exp;

  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (arb_if.Gnt != 0) begin
        if (exp_gnt_q.size() == 0) begin
          chk("gnt_unexpected", 32'(arb_if.Gnt), 32'd0);
        end else begin
          mon_e   = exp_gnt_q.pop_front();
          mon_exp = 4'b0001 << mon_e[9:8];
          chk("gnt_id", 32'(arb_if.Gnt), 32'(mon_exp));
          chk("gnt_tx_data", 32'(tx_data), 32'(mon_e[7:0]));
        end
      end
      if (arb_if.Done != 0) begin
        if (exp_done_q.size() == 0) begin
          chk("done_unexpected", 32'(arb_if.Done), 32'd0);
        end else begin
          mon_e   = exp_done_q.pop_front();
          mon_exp = 4'b0001 << mon_e[9:8];
          chk("done_id", 32'(arb_if.Done), 32'(mon_exp));
          chk("tx_data_held", 32'(tx_data), 32'(mon_e[7:0]));
        end
      end
      if (timeout_err) begin
        if (exp_err_q.size() == 0) begin
          chk("timeout_unexpected", 32'(timeout_err), 32'd0);
        end else begin
          mon_id = exp_err_q.pop_front();
          chk("err_id", 32'(err_id), 32'(mon_id));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_batch(input logic [3:0] mask, input int rise, input int hold,
                           input bit to_mode, input int pre_busy, input bit glitch);
    logic [3:0] pending;
    int n_ev, got, budget, lat, st_cnt, cyc_gnt, since_done, since_fall, blocked;
    bit first_gnt, prev_start, prev_busy, glitched, glitch_clr;
    tx_rise = rise;
    tx_hold = hold;
    no_resp = to_mode;
    model_plan(mask, to_mode);
    n_ev = 2 * $countones(mask);
    got = 0; budget = 3000; st_cnt = 0; cyc_gnt = 0;
    since_done = -1; since_fall = -1;
    first_gnt = 1'b0; glitched = 1'b0; glitch_clr = 1'b0;
    for (int i = 0; i < NR; i++) arb_if.Req_Data[i] = bd[i];
    if (pre_busy > 0) begin
      force_busy = 1'b1;
      @(negedge sys_clk);
      @(negedge sys_clk);
    end
    pending    = mask;
    arb_if.Req = pending;
    if (pre_busy > 0) begin
      blocked = 0;
      repeat (pre_busy) begin
        @(negedge sys_clk);
        if (arb_if.Gnt != 0) blocked++;
      end
      chk("busy_block_no_gnt", blocked, 0);
      force_busy = 1'b0;
    end
    lat        = tx_busy ? -1 : 0;
    prev_start = transmit_start;
    prev_busy  = tx_busy;
    while (got < n_ev && budget > 0) begin
      @(negedge sys_clk);
      budget--;
      if (glitch_clr) begin
        arb_if.Req = pending;
        glitch_clr = 1'b0;
      end
      if (lat >= 0 && !first_gnt) lat++;
      if (since_done >= 0) since_done++;
      if (since_fall >= 0) since_fall++;
      cyc_gnt++;
      if (arb_if.Gnt != 0) begin
        got++;
        if (!first_gnt) begin
          chk("grant_latency", lat, 1);
          first_gnt = 1'b1;
        end
        if (since_done >= 0) chk("gap_after_done", since_done, 1);
        since_done = -1;
        cyc_gnt    = 0;
        pending    = pending & ~arb_if.Gnt;
        arb_if.Req = pending;
      end
      if (transmit_start) begin
        st_cnt++;
      end else if (prev_start) begin
        if (to_mode) chk("start_width_timeout", st_cnt, TO);
        else         chk("start_width", st_cnt, rise + 1);
        st_cnt = 0;
      end
      prev_start = transmit_start;
      if (prev_busy && !tx_busy) since_fall = 0;
      prev_busy = tx_busy;
      if (arb_if.Done != 0) begin
        got++;
        chk("done_after_busy_fall", since_fall, 1);
        since_done = 0;
        since_fall = -1;
      end
      if (timeout_err) begin
        got++;
        chk("timeout_latency", cyc_gnt, TO);
        chk("timeout_start_low", 32'(transmit_start), 32'd0);
      end
      if (lat < 0 && !tx_busy) lat = 0;
      if (glitch && !glitched && dbg_state == WAIT_DONE) begin
        arb_if.Req = pending | 4'b1000;
        glitched   = 1'b1;
        glitch_clr = 1'b1;
      end
    end
    chk("batch_events", got, n_ev);
    arb_if.Req = '0;
    no_resp    = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(arb_if.Gnt), 32'd0);
    chk({tag, "_done"}, 32'(arb_if.Done), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_start"}, 32'(transmit_start), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    chk({tag, "_err_id"}, 32'(err_id), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    arb_if.Req      = '0;
    arb_if.Req_Data = '0;
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
    check_idle_outputs("reset");

    // fairness from pointer 0, then requester 0 again
    rand_data(); run_batch(4'b1111, 2, 3, 1'b0, 0, 1'b0);
    rand_data(); run_batch(4'b0001, 1, 2, 1'b0, 0, 1'b0);

    // single requester with a known byte
    rand_data(); bd[2] = 8'hA5;
    run_batch(4'b0100, 3, 10, 1'b0, 0, 1'b0);

    // transmitter held by another owner
    rand_data(); run_batch(4'b0001, 2, 4, 1'b0, 20, 1'b0);

    // start timeout, then retry alongside requester 2
    rand_data(); run_batch(4'b0010, 1, 1, 1'b1, 0, 1'b0);
    rand_data(); run_batch(4'b0110, 2, 3, 1'b0, 0, 1'b0);
    chk("err_id_hold", 32'(err_id), 32'd1);

    // one-cycle request from 3 while another byte is in flight
    rand_data(); run_batch(4'b0001, 2, 8, 1'b0, 0, 1'b1);

    // reset during WAIT_DONE
    rand_data();
    tx_rise = 2; tx_hold = 40; no_resp = 1'b0;
    model_plan(4'b1000, 1'b0);
    for (int i = 0; i < NR; i++) arb_if.Req_Data[i] = bd[i];
    arb_if.Req = 4'b1000;
    k = 0;
    while (dbg_state != WAIT_DONE && k < 100) begin
      @(negedge sys_clk);
      k++;
      if (arb_if.Gnt != 0) arb_if.Req = '0;
    end
    chk("reset_reached_wait_done", 32'(dbg_state == WAIT_DONE), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    exp_done_q.delete();
    m_ptr = 0;
    k = 0;
    while (tx_busy && k < 100) begin
      @(negedge sys_clk);
      k++;
    end
    chk("tx_idle_before_release", 32'(tx_busy), 32'd0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
    rand_data(); run_batch(4'b1001, 2, 3, 1'b0, 0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 12; n++) begin
      rand_data();
      run_batch(4'($urandom_range(1, 15)), $urandom_range(1, 4), $urandom_range(1, 8),
                1'b0, 0, 1'b0);
    end

    repeat (4) @(negedge sys_clk);
    chk("gnt_queue_drained", exp_gnt_q.size(), 0);
    chk("done_queue_drained", exp_done_q.size(), 0);
    chk("err_queue_drained", exp_err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter among `NUM_REQ` on-chip requesters (host writer, BIST engine, loopback echo, debug). It owns the transmitter's `Tx_Data` and `Transmit_Start` inputs, picks requesters round-robin, and captures the winner's byte. It sequences the start handshake against `Tx_Busy` and reports completion or start-timeout back to the requester. It sits between the requesters and the UART transmit datapath inside the UART top.

## Interface
Parameters:
- `DATA_BITS`, 8, character width; matches the UART.
- `NUM_REQ`, 4, number of requesters; legal range ≥ 2.
- `START_TIMEOUT`, 64, maximum cycles allowed in START for `Tx_Busy` to rise.

Ports:
- `SysClk`  in  1  system clock; single clock domain.
- `Rst`  in  1  reset, asynchronous, active-low.
- `Req`  in  NUM_REQ  requester i has a byte pending; level, held until `Gnt[i]`.
- `Req_Data`  in  NUM_REQ×DATA_BITS  packed array; byte of requester i.
- `Gnt`  out  NUM_REQ  one-hot, 1-cycle pulse; byte of requester i captured.
- `Done`  out  NUM_REQ  one-hot, 1-cycle pulse; requester i's byte fully transmitted.
- `Tx_Data`  out  DATA_BITS  to transmitter; stable from grant through WAIT_DONE.
- `Transmit_Start`  out  1  to transmitter.
- `Tx_Busy`  in  1  from transmitter.
- `Timeout_Err`  out  1  1-cycle pulse; start handshake timed out.
- `Err_Id`  out  $clog2(NUM_REQ)  requester that owned the timed-out grant; holds until the next error.

## Operation
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0.
- States: IDLE, START, WAIT_DONE.
- **IDLE**
  - When `|Req` and `!Tx_Busy`: select the first requesting index at or after the pointer, wrapping modulo `NUM_REQ`.
  - On that edge: register `Tx_Data <= Req_Data[win]`, pulse `Gnt[win]`, set pointer to `(win+1) mod NUM_REQ`, clear the counter, go to START.
  - If `Tx_Busy` is high, stay in IDLE. The transmitter is in use by another owner; no grant is issued.
- **START**
  - `Transmit_Start` = 1; the counter increments each cycle.
  - When `Tx_Busy` = 1: go to WAIT_DONE.
  - When the counter reaches `START_TIMEOUT` with `Tx_Busy` still low: pulse `Timeout_Err`, set `Err_Id = win`, return to IDLE. No `Done` is issued. The pointer has already advanced, so a retry by the same requester does not starve the others.
- **WAIT_DONE**
  - `Transmit_Start` = 0.
  - When `Tx_Busy` falls to 0: pulse `Done[win]` and go to IDLE.
- `Tx_Data` changes only on a grant edge.
- `Req[i]` deasserting before its grant withdraws the request. Deasserting after the grant has no effect on the transmission in flight.
- Reset asserted mid-operation: immediate return to reset values, including `Transmit_Start` = 0. No `Done` is issued for the aborted byte.

## Timing
- Grant latency: `Gnt` pulses on the first `SysClk` edge where IDLE, `|Req`, and `!Tx_Busy` all hold. `Transmit_Start` rises on that same edge.
- `Transmit_Start` stays high from the grant edge until the edge after `Tx_Busy` is sampled high. Minimum high time is 1 cycle.
- `Done` pulses on the edge where `Tx_Busy` is sampled low in WAIT_DONE.
- The next grant comes no earlier than the cycle after `Done`, so back-to-back bytes have one idle cycle between them.
- Timeout: `Timeout_Err` pulses exactly `START_TIMEOUT` cycles after `Gnt`.
- Counter width is `$clog2(START_TIMEOUT+1)`; the counter saturates and never wraps.
- Simultaneous requests are resolved only by the pointer; index order does not matter.

## Structure
- Shared package `uart_pkg`:
  - state enum `tx_arb_state_e` (IDLE, START, WAIT_DONE);
  - `REQ_ID_W` localparam function.
- Sub-module `uart_rr_pick`: combinational rotating-priority picker. Inputs are the request vector and the pointer; outputs are `win` and `valid`.
- The FSM, data register, counter, and pointer live in `uart_tx_arbiter`.

## Test plan
- **Single requester:** `Req=4'b0100`, `Req_Data[2]=8'hA5`; the transmitter model raises `Tx_Busy` 3 cycles after start and holds it 10 cycles.
  - Expect `Gnt=4'b0100` on the first edge and `Tx_Data=8'hA5`.
  - Expect `Transmit_Start` high for 4 cycles.
  - Expect `Done=4'b0100` one cycle after `Tx_Busy` falls.
- **Round-robin fairness:** `Req=4'b1111` held continuously. Expect the grant order 0, 1, 2, 3, 0, with exactly one `Done` between consecutive grants.
- **Busy blocking:** `Tx_Busy` forced high for 20 cycles with `Req=4'b0001`. Expect no `Gnt` until the cycle `Tx_Busy` is sampled low, then `Gnt=4'b0001`.
- **Timeout:** `START_TIMEOUT=64`, `Tx_Busy` held low, `Req=4'b0010`.
  - Expect `Timeout_Err` exactly 64 cycles after `Gnt`, with `Err_Id=1`.
  - Expect `Transmit_Start` low and no `Done`.
  - Expect the next grant to go to requester 2 if it is requesting.
- **Reset mid-transfer:** drive `Rst` low during WAIT_DONE.
  - Expect all outputs 0 asynchronously, the pointer at 0, and no `Done` pulse.
  - After release, `Req=4'b1000` with `Req=4'b0001` also set: expect requester 0 granted first.
- **Request withdrawal:** `Req[3]` pulses for 1 cycle while the arbiter is in WAIT_DONE. Expect no grant to 3.
